// File: rtl/decode_pkg.sv
// Decode-stage shared definitions: packed uop layout, functional unit IDs and
// the format one-hot codes used by the format-specific decoders.
package decode_pkg;

    localparam int OPCODE_W        = 12;
    localparam int ADDRESS_W       = 64;
    localparam int FUNC_UNIT_W     = 3;
    localparam int MAJ_ID_W        = 64;
    localparam int MIN_ID_W        = 5;
    localparam int NUM_MICRO_OPS_W = 5;
    localparam int IS_64BIT_W      = 1;
    localparam int PID_W           = 32;
    localparam int TID_W           = 64;
    localparam int MODIFIES_CR_W   = 1;
    localparam int BODY_W          = 28;

    // Fields are packed from bit 0 upward in the listed order.
    localparam int OPCODE_LSB        = 0;
    localparam int ADDRESS_LSB       = OPCODE_LSB + OPCODE_W;
    localparam int FUNC_UNIT_LSB     = ADDRESS_LSB + ADDRESS_W;
    localparam int MAJ_ID_LSB        = FUNC_UNIT_LSB + FUNC_UNIT_W;
    localparam int MIN_ID_LSB        = MAJ_ID_LSB + MAJ_ID_W;
    localparam int NUM_MICRO_OPS_LSB = MIN_ID_LSB + MIN_ID_W;
    localparam int IS_64BIT_LSB      = NUM_MICRO_OPS_LSB + NUM_MICRO_OPS_W;
    localparam int PID_LSB           = IS_64BIT_LSB + IS_64BIT_W;
    localparam int TID_LSB           = PID_LSB + PID_W;
    localparam int MODIFIES_CR_LSB   = TID_LSB + TID_W;
    localparam int BODY_LSB          = MODIFIES_CR_LSB + MODIFIES_CR_W;
    localparam int UOP_WIDTH         = BODY_LSB + BODY_W;

    typedef enum logic [FUNC_UNIT_W-1:0] {
        FU_FX     = 3'd0,
        FU_FP     = 3'd1,
        FU_VX     = 3'd2,
        FU_CR     = 3'd3,
        FU_LS     = 3'd4,
        FU_BRANCH = 3'd6
    } func_unit_e;

    localparam logic [5:0] FMT_I  = 6'b000001;
    localparam logic [5:0] FMT_B  = 6'b000010;
    localparam logic [5:0] FMT_D  = 6'b000100;
    localparam logic [5:0] FMT_DS = 6'b001000;
    localparam logic [5:0] FMT_X  = 6'b010000;
    localparam logic [5:0] FMT_XO = 6'b100000;

    function automatic logic [MAJ_ID_W-1:0] uop_maj_id(input logic [UOP_WIDTH-1:0] uop);
        return uop[MAJ_ID_LSB +: MAJ_ID_W];
    endfunction

endpackage

// File: rtl/uop_fifo.sv
// First-word-fall-through circular FIFO. Pop on empty is ignored; push while
// full is only taken together with a pop.
module uop_fifo #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   push,
    input  logic [width-1:0]       push_data,
    input  logic                   pop,
    output logic [width-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);

    localparam int PtrW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PtrW + 1)'(depth));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + {{PtrW{1'b0}}, do_push} - {{PtrW{1'b0}}, do_pop};
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clock_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/decode_uop_arbiter.sv
// Merges the registered outputs of the format decoders into one uop stream:
// per-lane pending slots, round-robin drain into a FWFT FIFO, shared stall.
module decode_uop_arbiter
    import decode_pkg::*;
#(
    parameter int numReq    = 4,
    parameter int uopWidth  = UOP_WIDTH,
    parameter int fifoDepth = 8
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [numReq-1:0]            decValid_i,
    input  logic [numReq*uopWidth-1:0]   decUop_i,
    output logic                         stall_o,
    output logic                         uopValid_o,
    output logic [uopWidth-1:0]          uop_o,
    input  logic                         uopReady_i,
    output logic [$clog2(fifoDepth):0]   fifoCount_o
);

    localparam int IdxW = (numReq > 1) ? $clog2(numReq) : 1;

    logic [numReq-1:0]   pend_valid;
    logic [uopWidth-1:0] pend_uop [numReq];
    logic [IdxW-1:0]     rr_ptr;
    logic [IdxW-1:0]     grant_idx;
    logic                grant_valid;
    logic [numReq-1:0]   drain_mask;
    logic [uopWidth-1:0] push_uop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    int                  pend_next;
    int                  cnt_next;

    assign uopValid_o = ~fifo_empty;
    assign fifo_pop   = uopValid_o & uopReady_i;
    assign push_uop   = pend_uop[grant_idx];

    // First pending slot at or after rr_ptr, wrapping; only when the FIFO can take it.
    always_comb begin : grant_search
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < numReq; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= numReq) cand = cand - numReq;
            if (!grant_valid && pend_valid[cand[IdxW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IdxW-1:0];
            end
        end
        if (fifo_full && !fifo_pop) grant_valid = 1'b0;
    end

    always_comb begin
        drain_mask = '0;
        if (grant_valid) drain_mask[grant_idx] = 1'b1;
    end

    // Low stall guarantees every lane launched next cycle finds its slot free.
    always_comb begin
        pend_next = $countones(pend_valid) + $countones(decValid_i) - (grant_valid ? 1 : 0);
        cnt_next  = int'(fifoCount_o) + (grant_valid ? 1 : 0) - (fifo_pop ? 1 : 0);
        stall_o   = (pend_next > 1) || (cnt_next > fifoDepth - 2) || reset_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pend_valid <= '0;
            rr_ptr     <= '0;
        end else begin
            pend_valid <= (pend_valid & ~drain_mask) | decValid_i;
            if (grant_valid) begin
                rr_ptr <= (grant_idx == IdxW'(numReq - 1)) ? '0 : grant_idx + IdxW'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        for (int k = 0; k < numReq; k++) begin
            if (decValid_i[k]) pend_uop[k] <= decUop_i[k*uopWidth +: uopWidth];
        end
    end

    uop_fifo #(
        .width(uopWidth),
        .depth(fifoDepth)
    ) u_fifo (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .push     (grant_valid),
        .push_data(push_uop),
        .pop      (fifo_pop),
        .pop_data (uop_o),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifoCount_o)
    );

endmodule

// File: tb/tb_decode_uop_arbiter.sv
// Randomized and directed bench for decode_uop_arbiter with a queue-based
// reference model and a scoreboard monitor on the dispatch handshake.
module tb_decode_uop_arbiter;
    import decode_pkg::*;

    localparam int N = 4;
    localparam int W = UOP_WIDTH;
    localparam int D = 8;

    logic                 clock_i     = 1'b0;
    logic                 reset_i     = 1'b1;
    logic                 uopReady_i  = 1'b0;
    logic [N-1:0]         decValid_i  = '0;
    logic [N*W-1:0]       decUop_i    = '0;
    logic                 stall_o;
    logic                 uopValid_o;
    logic [W-1:0]         uop_o;
    logic [$clog2(D):0]   fifoCount_o;

    decode_uop_arbiter #(.numReq(N), .uopWidth(W), .fifoDepth(D)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .decValid_i (decValid_i),
        .decUop_i   (decUop_i),
        .stall_o    (stall_o),
        .uopValid_o (uopValid_o),
        .uop_o      (uop_o),
        .uopReady_i (uopReady_i),
        .fifoCount_o(fifoCount_o)
    );

    always #5 clock_i = ~clock_i;

    int         total = 0;
    int         bad   = 0;
    logic [W-1:0] exp_q[$];
    int         out_lanes[$];
    int         n_out = 0;

    logic [W-1:0] m_slot [N];
    bit         m_valid [N];
    int         m_rr  = 0;
    int         m_cnt = 0;
    bit         armed = 0;
    int         seq   = 0;
    logic       last_stall = 1'b1;

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic logic [W-1:0] make_uop(input int lane);
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
        r[MAJ_ID_LSB +: MAJ_ID_W] = 64'(seq);
        r[PID_LSB +: PID_W]       = 32'(lane);
        seq++;
        return r[W-1:0];
    endfunction

    // Reference model: slots, round-robin pointer and FIFO occupancy, one step per cycle.
    always @(negedge clock_i) begin : model
        int pend_cnt, arr, g, pop, drain;
        pend_cnt = 0;
        arr      = 0;
        g        = -1;
        pop      = (m_cnt > 0 && uopReady_i) ? 1 : 0;
        for (int k = 0; k < N; k++) begin
            if (m_valid[k]) pend_cnt++;
            if (decValid_i[k]) arr++;
        end
        if (pend_cnt > 0 && (m_cnt < D || pop == 1)) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && m_valid[(m_rr + i) % N]) g = (m_rr + i) % N;
            end
        end
        drain = (g >= 0) ? 1 : 0;
        check("stall", stall_o,
              (reset_i || (pend_cnt - drain + arr > 1) || (m_cnt + drain - pop > D - 2)) ? 1 : 0);
        if (armed) begin
            check("valid", uopValid_o, (m_cnt > 0) ? 1 : 0);
            check("count", fifoCount_o, m_cnt);
        end
        if (reset_i) begin
            for (int k = 0; k < N; k++) m_valid[k] = 0;
            m_rr  = 0;
            m_cnt = 0;
            exp_q.delete();
            armed = 1;
        end else begin
            if (drain == 1) begin
                exp_q.push_back(m_slot[g]);
                m_valid[g] = 0;
                m_rr  = (g + 1) % N;
                m_cnt = m_cnt + 1;
            end
            m_cnt = m_cnt - pop;
            for (int k = 0; k < N; k++) begin
                if (decValid_i[k]) begin
                    check("slot_free", m_valid[k] ? 1 : 0, 0);
                    m_valid[k] = 1;
                    m_slot[k]  = decUop_i[k*W +: W];
                end
            end
        end
    end

    always @(negedge clock_i) begin : monitor
        logic [W-1:0] e;
        if (armed && !reset_i && uopValid_o && uopReady_i) begin
            total++;
            n_out++;
            out_lanes.push_back(int'(uop_o[PID_LSB +: PID_W]));
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stale_uop: got majId %0d want none", uop_maj_id(uop_o));
            end else begin
                e = exp_q.pop_front();
                if (uop_o !== e) begin
                    bad++;
                    $display("FAIL uop_data: got majId %0d want majId %0d",
                             uop_maj_id(uop_o), uop_maj_id(e));
                end
            end
        end
    end

    // Decoders only launch in a cycle following one where stall_o was low.
    task automatic step(input logic [N-1:0] want, input logic rdy, input logic rst,
                        output logic [N-1:0] sent);
        @(posedge clock_i);
        #1;
        reset_i    = rst;
        uopReady_i = rdy;
        sent       = '0;
        for (int k = 0; k < N; k++) begin
            if (want[k] && (rst || !last_stall)) begin
                sent[k] = 1'b1;
                decUop_i[k*W +: W] = make_uop(k);
            end
        end
        decValid_i = sent;
        @(negedge clock_i);
        last_stall = stall_o;
    endtask

    task automatic idle(input int n, input logic rdy);
        logic [N-1:0] s;
        repeat (n) step('0, rdy, 1'b0, s);
    endtask

    task automatic do_reset();
        logic [N-1:0] s;
        step('0, 1'b1, 1'b1, s);
        idle(2, 1'b1);
        out_lanes.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [N-1:0] s;
        int sent_cnt, stall_hits, first_valid, maxc, base;
        int burst_exp[4];
        int rr_exp[5];
        burst_exp = '{0, 1, 2, 3};
        rr_exp    = '{2, 3, 0, 1, 0};

        step(4'b1111, 1'b1, 1'b1, s);
        step(4'b1111, 1'b1, 1'b1, s);
        check("rst_stall", stall_o, 1);
        check("rst_valid", uopValid_o, 0);
        check("rst_count", fifoCount_o, 0);
        step('0, 1'b1, 1'b0, s);
        check("post_rst_stall", stall_o, 0);

        sent_cnt = 0; stall_hits = 0; first_valid = -1;
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 1'b1, 1'b0, s);
            sent_cnt   += int'(s[2]);
            stall_hits += int'(stall_o);
            if (first_valid < 0 && uopValid_o) first_valid = i;
        end
        check("stream_sent", sent_cnt, 20);
        check("stream_stall", stall_hits, 0);
        check("stream_latency", first_valid, 2);
        idle(4, 1'b1);

        do_reset();
        step(4'b1111, 1'b1, 1'b0, s);
        check("burst_sent", s, 4'b1111);
        stall_hits = int'(stall_o);
        repeat (6) begin
            step('0, 1'b1, 1'b0, s);
            stall_hits += int'(stall_o);
        end
        check("burst_stall_cycles", stall_hits, 3);
        check("burst_out_count", out_lanes.size(), 4);
        if (out_lanes.size() == 4)
            for (int i = 0; i < 4; i++) check("burst_lane_order", out_lanes[i], burst_exp[i]);

        do_reset();
        step(4'b0100, 1'b1, 1'b0, s);
        idle(3, 1'b1);
        step(4'b1001, 1'b1, 1'b0, s);
        idle(3, 1'b1);
        step(4'b0011, 1'b1, 1'b0, s);
        idle(4, 1'b1);
        check("rr_out_count", out_lanes.size(), 5);
        if (out_lanes.size() == 5)
            for (int i = 0; i < 5; i++) check("rr_lane_order", out_lanes[i], rr_exp[i]);

        do_reset();
        maxc = 0;
        repeat (14) begin
            step(4'b0001, 1'b0, 1'b0, s);
            if (int'(fifoCount_o) > maxc) maxc = int'(fifoCount_o);
        end
        check("full_max_count", maxc, D);
        idle(12, 1'b1);
        check("full_drained", fifoCount_o, 0);

        do_reset();
        repeat (5) step(4'b0001, 1'b0, 1'b0, s);
        step(4'b0111, 1'b0, 1'b0, s);
        step('0, 1'b0, 1'b1, s);
        step('0, 1'b1, 1'b0, s);
        check("midrst_count", fifoCount_o, 0);
        check("midrst_valid", uopValid_o, 0);
        base = n_out;
        idle(10, 1'b1);
        check("midrst_no_output", n_out - base, 0);

        do_reset();
        repeat (600) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'b0, s);
        end
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && !uopValid_o && m_valid[0] == 0 && m_valid[1] == 0 &&
                m_valid[2] == 0 && m_valid[3] == 0) break;
            step('0, 1'b1, 1'b0, s);
        end
        check("final_queue_empty", exp_q.size(), 0);
        check("final_count", fifoCount_o, 0);
        check("final_valid", uopValid_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
